rsa_roundtrip_ctrl: RTL and testbench
=====================================

Name: rsa_roundtrip_ctrl

Overview:
- Initiator side of the RSA engine go/done handshake; replaces hand-driven button loading.
- Latches plaintext, public exponent, private exponent and modulus, then runs encrypt (m^e mod n) followed by decrypt (c^d mod n) on one shared engine.
- Compares the recovered plaintext with the original and reports pass/fail, ciphertext and error code for the seven-segment and LED path.

Parameters:
- BITS, 32, operand/result width, matches the engine.
- TMO_W, 24, timeout counter width.
- TIMEOUT_CYCLES, 24'hFFFFFF, maximum cycles allowed in any engine-wait state.

Ports:
- clk  in  1  system clock, same clock as the engine.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a job.
- abort  in  1  single-cycle pulse; cancels a job.
- pt  in  BITS  plaintext.
- pub_e  in  BITS  public exponent.
- priv_d  in  BITS  private exponent.
- mod_n  in  BITS  modulus.
- eng_go  out  1  engine run request, level.
- eng_m  out  BITS  engine message operand.
- eng_e  out  BITS  engine exponent operand.
- eng_n  out  BITS  engine modulus operand.
- eng_r  in  BITS  engine result.
- eng_done  in  1  engine result valid, level.
- busy  out  1  job in progress.
- done  out  1  job finished, level.
- pass  out  1  round trip matched; valid when done=1.
- err  out  2  00 none, 01 timeout, 10 aborted, 11 bad argument.
- ct_out  out  BITS  captured ciphertext.
- rt_out  out  BITS  captured decrypted text.
- state_o  out  3  state encoding, for display.

Behaviour:
- Engine contract:
  - Engine computes while eng_go=1 and asserts eng_done when eng_r is valid.
  - eng_r is stable while eng_done=1.
  - Dropping eng_go returns the engine to idle; eng_done falls some cycles later.
  - Operands must be stable whenever eng_go=1.
- Reset values: all outputs 0; state IDLE; latched operands 0; timeout counter 0.
- States (state_o): IDLE=0, ENC_RUN=1, ENC_REL=2, DEC_RUN=3, DEC_REL=4, CHECK=5, FIN=6, ERR=7.
- IDLE / FIN / ERR accept start:
  - Latch pt, pub_e, priv_d, mod_n.
  - Clear done, pass, err, ct_out, rt_out.
  - If mod_n<2 or pt>=mod_n: go to ERR, err=11, next cycle; eng_go never asserts.
  - Otherwise go to ENC_RUN next cycle.
- ENC_RUN:
  - eng_go=1, eng_m=pt_q, eng_e=pub_e_q, eng_n=n_q.
  - On the first cycle eng_done=1: ct_out<=eng_r, go to ENC_REL.
- ENC_REL: eng_go=0; wait for eng_done=0, then go to DEC_RUN.
- DEC_RUN:
  - eng_go=1, eng_m=ct_out, eng_e=priv_d_q.
  - On eng_done=1: rt_out<=eng_r, go to DEC_REL.
- DEC_REL: eng_go=0; wait for eng_done=0, then go to CHECK.
- CHECK: one cycle; pass<=(rt_out==pt_q); go to FIN.
- FIN: done=1, held until the next start or reset.
- busy=1 in states 1–5.
- Timeout:
  - Counter clears on every state entry and increments each cycle in states 1–4.
  - When it reaches TIMEOUT_CYCLES: ERR, err=01, eng_go=0.
- abort in states 1–5: ERR, err=10, eng_go=0 next cycle. abort in IDLE, FIN or ERR is ignored.
- ERR: done=1, pass=0.
- Simultaneous events:
  - start while busy is ignored.
  - abort and eng_done in the same cycle: abort wins, no capture.
  - eng_done and timeout expiry in the same cycle: eng_done wins.
- eng_m, eng_e, eng_n hold their last values outside RUN states.
- Asynchronous reset mid-job: immediate return to IDLE; eng_go=0 asynchronously.

Test Plan:
- Nominal: n=3233, e=17, d=2753, pt=65, engine model latency 40 cycles.
  - ct_out=2790, rt_out=65.
  - pass=1, done=1, err=00.
  - Exactly two eng_go high intervals.
- Wrong key: same as nominal but d=2752 → done=1, pass=0, err=00, ct_out=2790.
- Bad argument: pt=3233, n=3233 → ERR one cycle after start, err=11, eng_go stays 0. Repeat with n=1 → same result.
- Timeout: TIMEOUT_CYCLES=100, engine never asserts done.
  - ERR with err=01 exactly 100 cycles after ENC_RUN entry.
  - eng_go=0 the following cycle.
- Abort mid-job: abort pulse 10 cycles into DEC_RUN → err=10, busy=0, eng_go=0 next cycle, ct_out retains 2790. A new start then completes the nominal case with pass=1.
- Reset and ignored start:
  - reset_n low mid-ENC_RUN → all outputs 0 immediately.
  - After release, start while busy is ignored; the job's operands are unchanged.
  - Engine release handshake: engine holds eng_done 5 cycles after go drops → DEC_RUN entered only after eng_done=0.

Source files
------------

// File: rtl/rsa_roundtrip_ctrl_if.sv
// rsa_roundtrip_ctrl_if: go/done handshake and operand bus between the round-trip controller and the RSA engine.
interface rsa_roundtrip_ctrl_if #(
  parameter int BITS = 32
);
  logic            eng_go;
  logic            eng_done;
  logic [BITS-1:0] eng_m;
  logic [BITS-1:0] eng_e;
  logic [BITS-1:0] eng_n;
  logic [BITS-1:0] eng_r;
  modport master (output eng_go, eng_m, eng_e, eng_n, input eng_r, eng_done);
  modport slave  (input eng_go, eng_m, eng_e, eng_n, output eng_r, eng_done);
endinterface

// File: rtl/rsa_roundtrip_ctrl.sv
// rsa_roundtrip_ctrl: runs encrypt then decrypt on one shared RSA engine and reports whether the plaintext survives the round trip.
module rsa_roundtrip_ctrl #(
  parameter int              BITS           = 32,
  parameter int              TMO_W          = 24,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [BITS-1:0]       i_pt,
  input  logic [BITS-1:0]       i_pub_e,
  input  logic [BITS-1:0]       i_priv_d,
  input  logic [BITS-1:0]       i_mod_n,
  rsa_roundtrip_ctrl_if.master  eng,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [1:0]            o_err,
  output logic [BITS-1:0]       o_ct_out,
  output logic [BITS-1:0]       o_rt_out,
  output logic [2:0]            o_state
);
  typedef enum logic [2:0] {
    S_IDLE, S_ENC_RUN, S_ENC_REL, S_DEC_RUN, S_DEC_REL, S_CHECK, S_FIN, S_ERR
  } state_t;
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CYCLES - 1'b1;
  state_t            r_state, w_nxt;
  logic [1:0]        r_err, w_err;
  logic [TMO_W-1:0]  r_tmo;
  logic [BITS-1:0]   r_pt, r_pe, r_d, r_n, r_ct, r_rt, r_m, r_e, r_en;
  logic              r_pass;
  logic              w_idle, w_wait, w_bad, w_tmo;
  assign w_idle  = r_state == S_IDLE || r_state == S_FIN || r_state == S_ERR;
  assign w_wait  = r_state inside {S_ENC_RUN, S_ENC_REL, S_DEC_RUN, S_DEC_REL};
  assign w_bad   = i_mod_n < BITS'(2) || i_pt >= i_mod_n;
  assign w_tmo   = r_tmo == TMO_LAST;
  // Combinational from state so an asynchronous reset drops go at once.
  assign eng.eng_go = r_state == S_ENC_RUN || r_state == S_DEC_RUN;
  assign eng.eng_m  = r_m;
  assign eng.eng_e  = r_e;
  assign eng.eng_n  = r_en;
  assign o_busy   = !w_idle;
  assign o_done   = r_state == S_FIN || r_state == S_ERR;
  assign o_pass   = r_pass;
  assign o_err    = r_err;
  assign o_ct_out = r_ct;
  assign o_rt_out = r_rt;
  assign o_state  = r_state;
  always_comb begin
    w_nxt = r_state;
    w_err = r_err;
    case (r_state)
      S_IDLE, S_FIN, S_ERR: if (i_start) begin
        w_nxt = w_bad ? S_ERR : S_ENC_RUN;
        w_err = w_bad ? 2'b11 : 2'b00;
      end
      S_ENC_RUN: w_nxt = eng.eng_done ? S_ENC_REL : w_tmo ? S_ERR : r_state;
      S_ENC_REL: w_nxt = !eng.eng_done ? S_DEC_RUN : w_tmo ? S_ERR : r_state;
      S_DEC_RUN: w_nxt = eng.eng_done ? S_DEC_REL : w_tmo ? S_ERR : r_state;
      S_DEC_REL: w_nxt = !eng.eng_done ? S_CHECK : w_tmo ? S_ERR : r_state;
      S_CHECK:   w_nxt = S_FIN;
      default:   w_nxt = r_state;
    endcase
    // Abort overrides any engine event in the same cycle, so nothing is captured.
    if (o_busy && i_abort) begin
      w_nxt = S_ERR;
      w_err = 2'b10;
    end else if (w_wait && w_nxt == S_ERR) begin
      w_err = 2'b01;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_err   <= '0;
      r_tmo   <= '0;
      r_pt    <= '0;
      r_pe    <= '0;
      r_d     <= '0;
      r_n     <= '0;
      r_ct    <= '0;
      r_rt    <= '0;
      r_m     <= '0;
      r_e     <= '0;
      r_en    <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err;
      r_tmo   <= (w_wait && w_nxt == r_state) ? r_tmo + 1'b1 : '0;
      if (w_idle && i_start) begin
        r_pt   <= i_pt;
        r_pe   <= i_pub_e;
        r_d    <= i_priv_d;
        r_n    <= i_mod_n;
        r_ct   <= '0;
        r_rt   <= '0;
        r_pass <= 1'b0;
        if (!w_bad) begin
          r_m  <= i_pt;
          r_e  <= i_pub_e;
          r_en <= i_mod_n;
        end
      end
      if (r_state == S_ENC_RUN && w_nxt == S_ENC_REL) r_ct <= eng.eng_r;
      if (r_state == S_ENC_REL && w_nxt == S_DEC_RUN) begin
        r_m  <= r_ct;
        r_e  <= r_d;
        r_en <= r_n;
      end
      if (r_state == S_DEC_RUN && w_nxt == S_DEC_REL) r_rt <= eng.eng_r;
      if (r_state == S_CHECK && w_nxt == S_FIN) r_pass <= r_rt == r_pt;
    end
  end
endmodule

// File: tb/tb_rsa_roundtrip_ctrl.sv
// tb_rsa_roundtrip_ctrl: directed scenarios against a behavioural RSA engine with configurable latency and release hold.
module tb_rsa_roundtrip_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_start = 1'b0, i_abort = 1'b0;
  logic [31:0] i_pt = '0, i_pub_e = '0, i_priv_d = '0, i_mod_n = '0;
  logic        o_busy, o_done, o_pass;
  logic [1:0]  o_err;
  logic [31:0] o_ct_out, o_rt_out;
  logic [2:0]  o_state;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  rsa_roundtrip_ctrl_if #(.BITS(32)) eif ();
  rsa_roundtrip_ctrl #(.BITS(32), .TMO_W(24), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_pt(i_pt), .i_pub_e(i_pub_e), .i_priv_d(i_priv_d), .i_mod_n(i_mod_n),
    .eng(eif), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err(o_err),
    .o_ct_out(o_ct_out), .o_rt_out(o_rt_out), .o_state(o_state)
  );

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    logic [63:0] r, x;
    r = 64'd1;
    x = {32'd0, b} % {32'd0, n};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % {32'd0, n};
      x = (x * x) % {32'd0, n};
    end
    return r[31:0];
  endfunction

  // Engine model: result after lat cycles of go, done held hold cycles after go drops.
  int   lat = 40, hold = 1, cnt, rel;
  bit   never = 1'b0;
  logic m_done;
  logic [31:0] m_r;
  assign eif.eng_done = m_done;
  assign eif.eng_r    = m_r;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_done <= 1'b0; m_r <= '0; cnt <= 0; rel <= 0;
    end else if (eif.eng_go) begin
      rel <= 0;
      if (!m_done && !never) begin
        if (cnt == lat - 1) begin
          m_done <= 1'b1;
          m_r    <= modexp(eif.eng_m, eif.eng_e, eif.eng_n);
        end else cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
      if (m_done) begin
        if (rel >= hold - 1) m_done <= 1'b0;
        else rel <= rel + 1;
      end
    end
  end

  logic go_q = 1'b0;
  int   go_rises = 0;
  always @(posedge clk) begin
    go_q <= eif.eng_go;
    if (eif.eng_go && !go_q) go_rises <= go_rises + 1;
  end

  task automatic set_ops(input logic [31:0] pt, input logic [31:0] e, input logic [31:0] d, input logic [31:0] n);
    i_pt = pt; i_pub_e = e; i_priv_d = d; i_mod_n = n;
  endtask

  task automatic pulse_start;
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k = 0;
    while (o_state !== s && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (o_state !== s) begin
      failures++;
      $display("FAIL wait_state got=%0d want=%0d", o_state, s);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({o_busy, o_done, o_pass, o_err, o_state, eif.eng_go} !== 9'd0 || o_ct_out !== 0 || o_rt_out !== 0 || eif.eng_m !== 0) begin
      failures++;
      $display("FAIL reset_outputs state=%0d busy=%0d done=%0d go=%0d ct=%0d want all 0", o_state, o_busy, o_done, eif.eng_go, o_ct_out);
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_nominal;
    int base = go_rises;
    set_ops(65, 17, 2753, 3233);
    pulse_start;
    wait_state(3'd6);
    checks++;
    if (o_ct_out !== 32'd2790) begin failures++; $display("FAIL nominal_ct got=%0d want=2790", o_ct_out); end
    checks++;
    if (o_rt_out !== 32'd65) begin failures++; $display("FAIL nominal_rt got=%0d want=65", o_rt_out); end
    checks++;
    if ({o_pass, o_done, o_err, o_busy} !== 5'b11000) begin
      failures++;
      $display("FAIL nominal_flags pass=%0d done=%0d err=%0d busy=%0d want 1 1 0 0", o_pass, o_done, o_err, o_busy);
    end
    checks++;
    if (go_rises - base !== 2) begin failures++; $display("FAIL nominal_go_intervals got=%0d want=2", go_rises - base); end
  endtask

  task automatic test_wrong_key;
    set_ops(65, 17, 2752, 3233);
    pulse_start;
    wait_state(3'd6);
    checks++;
    if ({o_done, o_pass, o_err} !== 4'b1000) begin
      failures++;
      $display("FAIL wrongkey_flags done=%0d pass=%0d err=%0d want 1 0 0", o_done, o_pass, o_err);
    end
    checks++;
    if (o_ct_out !== 32'd2790) begin failures++; $display("FAIL wrongkey_ct got=%0d want=2790", o_ct_out); end
  endtask

  task automatic test_bad_arg(input logic [31:0] pt, input logic [31:0] n);
    int base = go_rises;
    set_ops(pt, 17, 2753, n);
    pulse_start;
    checks++;
    if (o_state !== 3'd7 || o_err !== 2'b11 || o_done !== 1'b1 || o_pass !== 1'b0) begin
      failures++;
      $display("FAIL badarg_n%0d state=%0d err=%0d done=%0d pass=%0d want 7 3 1 0", n, o_state, o_err, o_done, o_pass);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (go_rises - base !== 0 || eif.eng_go !== 1'b0) begin
      failures++;
      $display("FAIL badarg_go_n%0d rises=%0d go=%0d want 0 0", n, go_rises - base, eif.eng_go);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    never = 1'b1;
    set_ops(65, 17, 2753, 3233);
    pulse_start;
    checks++;
    if (o_state !== 3'd1) begin failures++; $display("FAIL timeout_entry got=%0d want=1", o_state); end
    while (o_state !== 3'd7 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 100) begin failures++; $display("FAIL timeout_cycles got=%0d want=100", n); end
    checks++;
    if (o_err !== 2'b01 || eif.eng_go !== 1'b0 || o_done !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flags err=%0d go=%0d done=%0d want 1 0 1", o_err, eif.eng_go, o_done);
    end
    never = 1'b0;
  endtask

  task automatic test_abort;
    set_ops(65, 17, 2753, 3233);
    pulse_start;
    wait_state(3'd3);
    repeat (9) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk) i_abort = 1'b0;
    checks++;
    if (o_state !== 3'd7 || o_err !== 2'b10 || o_busy !== 1'b0 || eif.eng_go !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags state=%0d err=%0d busy=%0d go=%0d want 7 2 0 0", o_state, o_err, o_busy, eif.eng_go);
    end
    checks++;
    if (o_ct_out !== 32'd2790) begin failures++; $display("FAIL abort_ct got=%0d want=2790", o_ct_out); end
    pulse_start;
    wait_state(3'd6);
    checks++;
    if (o_pass !== 1'b1 || o_err !== 2'b00) begin
      failures++;
      $display("FAIL abort_rerun pass=%0d err=%0d want 1 0", o_pass, o_err);
    end
  endtask

  task automatic test_reset_mid;
    set_ops(65, 17, 2753, 3233);
    pulse_start;
    wait_state(3'd1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_pass, o_err, o_state, eif.eng_go} !== 9'd0 || o_ct_out !== 0 || o_rt_out !== 0 || eif.eng_m !== 0) begin
      failures++;
      $display("FAIL reset_mid state=%0d busy=%0d go=%0d done=%0d m=%0d want all 0", o_state, o_busy, eif.eng_go, o_done, eif.eng_m);
    end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_ignored_start;
    set_ops(65, 17, 2753, 3233);
    pulse_start;
    repeat (3) @(negedge clk);
    set_ops(7, 3, 5, 11);
    pulse_start;
    checks++;
    if (o_state !== 3'd1 || eif.eng_m !== 32'd65 || eif.eng_e !== 32'd17 || eif.eng_n !== 32'd3233) begin
      failures++;
      $display("FAIL ignored_start state=%0d m=%0d e=%0d n=%0d want 1 65 17 3233", o_state, eif.eng_m, eif.eng_e, eif.eng_n);
    end
    wait_state(3'd6);
    checks++;
    if (o_ct_out !== 32'd2790 || o_pass !== 1'b1) begin
      failures++;
      $display("FAIL ignored_result ct=%0d pass=%0d want 2790 1", o_ct_out, o_pass);
    end
  endtask

  task automatic test_release;
    int n = 0;
    hold = 5;
    set_ops(65, 17, 2753, 3233);
    pulse_start;
    wait_state(3'd2);
    while (o_state === 3'd2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 6 || o_state !== 3'd3) begin
      failures++;
      $display("FAIL release_wait cycles=%0d state=%0d want 6 3", n, o_state);
    end
    wait_state(3'd6);
    checks++;
    if (o_pass !== 1'b1) begin failures++; $display("FAIL release_pass got=%0d want=1", o_pass); end
    hold = 1;
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_wrong_key;
    test_bad_arg(32'd3233, 32'd3233);
    test_bad_arg(32'd0, 32'd1);
    test_timeout;
    test_abort;
    test_reset_mid;
    test_ignored_start;
    test_release;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
